// File: rtl/instr_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_buffer_if
//  Purpose  : Handshake and decoded-field bundle between the program source,
//             the instruction fetch buffer and the controller.
//  Revision : 1.0
// ============================================================================
interface instr_fetch_buffer_if #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 24,
    parameter int DATA_W  = 8
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] instr_in;
    logic               instr_in_v;
    logic               instr_in_rdy;
    logic               stalled;
    logic               internal_reset;
    logic [2:0]         opcode;
    logic [2:0]         src1;
    logic [2:0]         src2;
    logic [2:0]         dst;
    logic [DATA_W-1:0]  imm;
    logic               instv;
    logic [c_CNT_W-1:0] count;
    logic               ovf;

    modport master (
        output instr_in, instr_in_v, stalled, internal_reset,
        input  instr_in_rdy, opcode, src1, src2, dst, imm, instv, count, ovf
    );

    modport slave (
        input  instr_in, instr_in_v, stalled, internal_reset,
        output instr_in_rdy, opcode, src1, src2, dst, imm, instv, count, ovf
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_buffer
//  Purpose  : Small instruction FIFO that decodes its head entry for the
//             controller, with stall hold, flush and sticky overflow.
//  Revision : 1.0
// ============================================================================
module instr_fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 24,
    parameter int DATA_W  = 8
) (
    input  wire logic           clock,
    input  wire logic           reset,
    instr_fetch_buffer_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 12 + DATA_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Entries keep only opcode/register fields and the immediate.
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic [c_ENT_W-1:0] r_last;

    logic               w_full;
    logic               w_empty;
    logic               w_flush;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_entry;
    logic [c_ENT_W-1:0] w_head;
    logic [c_ENT_W-1:0] w_show;
    logic               w_unused_rsvd;

    assign w_full        = (r_count == c_FULL);
    assign w_empty       = (r_count == '0);
    assign w_flush       = bus.internal_reset;
    assign w_push        = bus.instr_in_v && !w_full && !w_flush;
    assign w_pop         = !w_empty && !bus.stalled && !w_flush;
    assign w_entry       = {bus.instr_in[INSTR_W-1:12], bus.instr_in[DATA_W-1:0]};
    assign w_unused_rsvd = &{1'b0, bus.instr_in[11:8]};
    assign w_head        = r_mem[r_rd_ptr];
    // When empty, the outputs keep showing the last entry that was at the head.
    assign w_show        = w_empty ? r_last : w_head;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_last   <= '0;
        end else begin
            if (!w_empty) begin
                r_last <= w_head;
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (bus.instr_in_v && w_full) begin
                    r_ovf <= 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.opcode       = w_show[DATA_W+9 +: 3];
    assign bus.src1         = w_show[DATA_W+6 +: 3];
    assign bus.src2         = w_show[DATA_W+3 +: 3];
    assign bus.dst          = w_show[DATA_W   +: 3];
    assign bus.imm          = w_show[DATA_W-1:0];
    assign bus.instv        = !w_empty;
    assign bus.count        = r_count;
    assign bus.ovf          = r_ovf;
    // Held low while reset is asserted, then follows the registered fill level.
    assign bus.instr_in_rdy = reset && !w_full;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_buffer
//  Purpose  : Queue-model checked bench for instr_fetch_buffer.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch_buffer;
    localparam int DEPTH   = 4;
    localparam int INSTR_W = 24;
    localparam int DATA_W  = 8;

    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_OUT = 3'd6;
    localparam logic [2:0] R_IMM  = 3'd7;
    localparam logic [2:0] R1     = 3'd1;
    localparam logic [2:0] R2     = 3'd2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    instr_fetch_buffer_if #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] mq[$];
    logic        m_ovf  = 1'b0;
    logic [23:0] m_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [23:0] s;
        s = (mq.size() != 0) ? mq[0] : m_last;
        chk("instv", 32'(bus.instv), 32'(mq.size() != 0));
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("rdy",   32'(bus.instr_in_rdy), 32'(mq.size() != DEPTH));
        chk("ovf",   32'(bus.ovf), 32'(m_ovf));
        chk("opcode", 32'(bus.opcode), 32'(s[23:21]));
        chk("src1",   32'(bus.src1), 32'(s[20:18]));
        chk("src2",   32'(bus.src2), 32'(s[17:15]));
        chk("dst",    32'(bus.dst), 32'(s[14:12]));
        chk("imm",    32'(bus.imm), 32'(s[7:0]));
    endtask

    // Buffer behaviour as a plain queue: pop from front, push to back.
    task automatic model_edge(input logic v, input logic [23:0] w, input logic st, input logic fl);
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (mq.size() != 0) m_last = mq[0];
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && !st) void'(mq.pop_front());
            if (v) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back(w);
            end
        end
    endtask

    task automatic step(input logic v, input logic [23:0] w, input logic st, input logic fl);
        bus.instr_in_v     = v;
        bus.instr_in       = w;
        bus.stalled        = st;
        bus.internal_reset = fl;
        @(posedge clock);
        model_edge(v, w, st, fl);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        logic [23:0] w1, w3, tmp;
        logic [23:0] words [4];

        bus.instr_in_v     = 1'b0;
        bus.instr_in       = '0;
        bus.stalled        = 1'b0;
        bus.internal_reset = 1'b0;

        repeat (2) @(negedge clock);
        chk("reset_rdy",   32'(bus.instr_in_rdy), 32'd0);
        chk("reset_instv", 32'(bus.instv), 32'd0);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_ovf",   32'(bus.ovf), 32'd0);
        chk("reset_opcode", 32'(bus.opcode), 32'd0);
        reset = 1'b1;
        #1;
        chk("rdy_after_reset", 32'(bus.instr_in_rdy), 32'd1);

        // Single LD push
        w1 = {OP_LD, R_IMM, R1, 3'd3, 4'hA, 8'h5A};
        step(1'b1, w1, 1'b0, 1'b0);
        chk("t1_instv",  32'(bus.instv), 32'd1);
        chk("t1_opcode", 32'(bus.opcode), 32'(OP_LD));
        chk("t1_src1",   32'(bus.src1), 32'(R_IMM));
        chk("t1_src2",   32'(bus.src2), 32'(R1));
        chk("t1_imm",    32'(bus.imm), 32'h5A);
        step(1'b0, 24'h0, 1'b0, 1'b0);
        chk("t1_count_after", 32'(bus.count), 32'd0);
        chk("t1_instv_after", 32'(bus.instv), 32'd0);
        chk("t1_hold_opcode", 32'(bus.opcode), 32'(OP_LD));

        // Fill while stalled, overflow, then drain in order
        for (int i = 0; i < 4; i++) begin
            words[i] = 24'($urandom);
            step(1'b1, words[i], 1'b1, 1'b0);
        end
        chk("t2_count_full", 32'(bus.count), 32'd4);
        chk("t2_rdy_full",   32'(bus.instr_in_rdy), 32'd0);
        step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        chk("t2_ovf",        32'(bus.ovf), 32'd1);
        chk("t2_count_kept", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_op",  32'(bus.opcode), 32'(words[i][23:21]));
            chk("t2_order_imm", 32'(bus.imm), 32'(words[i][7:0]));
            step(1'b0, 24'h0, 1'b0, 1'b0);
        end
        chk("t2_count_drained", 32'(bus.count), 32'd0);
        chk("t2_ovf_sticky",    32'(bus.ovf), 32'd1);

        // Stall hold on OUT R2,R1
        w3 = {OP_OUT, R2, R1, 3'd4, 4'h0, 8'h11};
        step(1'b1, w3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 24'h0, 1'b1, 1'b0);
            chk("t3_op_stable",   32'(bus.opcode), 32'(OP_OUT));
            chk("t3_src1_stable", 32'(bus.src1), 32'(R2));
            chk("t3_src2_stable", 32'(bus.src2), 32'(R1));
            chk("t3_count_held",  32'(bus.count), 32'd1);
        end
        step(1'b0, 24'h0, 1'b0, 1'b0);
        chk("t3_popped", 32'(bus.count), 32'd0);

        // Streaming at count=2, pointers wrap
        for (int i = 0; i < 2; i++) step(1'b1, 24'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 24'($urandom), 1'b0, 1'b0);
            chk("t4_count_steady", 32'(bus.count), 32'd2);
        end
        repeat (2) step(1'b0, 24'h0, 1'b0, 1'b0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) step(1'b1, 24'($urandom), 1'b1, 1'b0);
        chk("t5_count3", 32'(bus.count), 32'd3);
        step(1'b1, 24'h123456, 1'b0, 1'b1);
        chk("t5_count0", 32'(bus.count), 32'd0);
        chk("t5_instv0", 32'(bus.instv), 32'd0);
        chk("t5_ovf",    32'(bus.ovf), 32'd1);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 2; i++) step(1'b1, 24'($urandom), 1'b1, 1'b0);
        bus.instr_in_v = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_instv", 32'(bus.instv), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_rdy",   32'(bus.instr_in_rdy), 32'd0);
        chk("t6_ovf",   32'(bus.ovf), 32'd0);
        mq.delete();
        m_ovf  = 1'b0;
        m_last = '0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("t6_rdy_after", 32'(bus.instr_in_rdy), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            tmp = 24'($urandom);
            step(($urandom_range(0, 99) < 70), tmp,
                 ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
